adc_avg_fifo: RTL and testbench

Decimating averager and sample buffer placed directly downstream of `pwm_ramp`. It accepts each converted code on `adc_value_i`/`adc_valid_i` and sums blocks of 2^k samples. Each block average is pushed into a small synchronous FIFO, which the bus or host side drains with a valid/ready handshake. It cuts the comparator noise of the ramp ADC and decouples conversion rate from consumer rate.

---
 rtl/adc_avg_fifo_pkg.sv | 17 +
 rtl/adc_avg_fifo_mem.sv | 60 ++++++
 rtl/adc_avg_fifo.sv | 118 +++++++++++
 tb/tb_adc_avg_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_avg_fifo_pkg.sv
// Shared defaults, derived widths and the ADC code type for the decimating averager.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adc_avg_fifo_pkg;

    localparam int DEF_NBITS        = 6;
    localparam int DEF_MAX_LOG2_AVG = 4;
    localparam int DEF_DEPTH        = 8;

    localparam int ACC_W = DEF_NBITS + DEF_MAX_LOG2_AVG;
    localparam int PTR_W = $clog2(DEF_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int K_W   = $clog2(DEF_MAX_LOG2_AVG + 1);

    typedef logic [DEF_NBITS-1:0] adc_code_t;

endpackage

// File: rtl/adc_avg_fifo_mem.sv
// Synchronous FIFO for block averages; head is shown combinationally from storage.
// Latency: a push is visible at the head one cycle later when the FIFO was empty.
// Backpressure: a push into a full FIFO lands only if a pop happens in the same cycle.
module adc_avg_fifo_mem #(
    parameter  int W     = 6,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          valid_o,
    output logic          full_o,
    output logic [LW-1:0] level_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          empty;
    logic          do_pop;
    logic          do_push;

    assign empty   = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i && !empty;
    // When full, the slot being popped is the one written, so the new entry ends up last.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/adc_avg_fifo.sv
// Sums blocks of 2^k ADC codes, pushes each average into a FIFO; ADC_AVG_WINDOW_EN adds a sticky window alarm.
// Latency: block average at FIFO head one cycle after the completing sample (FIFO empty).
// Backpressure: valid/ready on the output; averages arriving at a full, unpopped FIFO are dropped and flagged.
module adc_avg_fifo #(
    parameter int NBITS        = adc_avg_fifo_pkg::DEF_NBITS,
    parameter int MAX_LOG2_AVG = adc_avg_fifo_pkg::DEF_MAX_LOG2_AVG,
    parameter int DEPTH        = adc_avg_fifo_pkg::DEF_DEPTH
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               enable_i,
    input  logic                               clear_i,
    input  logic [$clog2(MAX_LOG2_AVG+1)-1:0]  avg_log2_i,
    input  logic [NBITS-1:0]                   adc_value_i,
    input  logic                               adc_valid_i,
    output logic [NBITS-1:0]                   data_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [$clog2(DEPTH):0]             level_o,
`ifdef ADC_AVG_WINDOW_EN
    input  logic [NBITS-1:0]                   thr_lo_i,
    input  logic [NBITS-1:0]                   thr_hi_i,
    output logic                               alarm_o,
`endif
    output logic                               overflow_o
);

    import adc_avg_fifo_pkg::*;

    localparam int AW = NBITS + MAX_LOG2_AVG;
    localparam int KW = $clog2(MAX_LOG2_AVG + 1);
    localparam int CW = (MAX_LOG2_AVG > 0) ? MAX_LOG2_AVG : 1;

    logic [AW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic [KW-1:0]    k_q;
    logic             ovf_q;

    logic             accept;
    logic [KW-1:0]    k_in;
    logic [KW-1:0]    k_eff;
    logic             last;
    logic [AW-1:0]    sum;
    logic [NBITS-1:0] avg;
    logic             avg_vld;
    logic             fifo_full;
    logic             drop;

    assign accept = enable_i && adc_valid_i && !clear_i;
    assign k_in   = (avg_log2_i > KW'(MAX_LOG2_AVG)) ? KW'(MAX_LOG2_AVG) : avg_log2_i;
    // The first sample of a block uses the exponent it latches, not the stale k_q.
    assign k_eff  = (cnt_q == '0) ? k_in : k_q;
    assign last   = (cnt_q == CW'((32'd1 << k_eff) - 32'd1));
    assign sum    = acc_q + AW'(adc_value_i);
    assign avg    = NBITS'(sum >> k_eff);

    assign avg_vld = accept && last;
    assign drop    = avg_vld && fifo_full && !ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
            k_q   <= '0;
            ovf_q <= 1'b0;
        end else if (clear_i) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            if (cnt_q == '0) k_q <= k_in;
            if (last) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= sum;
                cnt_q <= cnt_q + CW'(1);
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign overflow_o = ovf_q;

`ifdef ADC_AVG_WINDOW_EN
    logic alarm_q;

    // Dropped averages are still judged against the window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alarm_q <= 1'b0;
        end else if (clear_i) begin
            alarm_q <= 1'b0;
        end else if (avg_vld && ((avg < thr_lo_i) || (avg > thr_hi_i))) begin
            alarm_q <= 1'b1;
        end
    end

    assign alarm_o = alarm_q;
`endif

    adc_avg_fifo_mem #(
        .W     (NBITS),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (avg_vld),
        .data_i  (avg),
        .pop_i   (ready_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .full_o  (fifo_full),
        .level_o (level_o)
    );

endmodule

// File: tb/tb_adc_avg_fifo.sv
// Directed bench for adc_avg_fifo: averaging, FIFO ordering/overflow, clear, reset, optional window alarm.
module tb_adc_avg_fifo;

    localparam int NB = 6;
    localparam int ML = 4;
    localparam int DP = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          enable_i;
    logic          clear_i;
    logic [2:0]    avg_log2_i;
    logic [NB-1:0] adc_value_i;
    logic          adc_valid_i;
    logic [NB-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic [3:0]    level_o;
    logic          overflow_o;
`ifdef ADC_AVG_WINDOW_EN
    logic [NB-1:0] thr_lo_i;
    logic [NB-1:0] thr_hi_i;
    logic          alarm_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    adc_avg_fifo #(.NBITS(NB), .MAX_LOG2_AVG(ML), .DEPTH(DP)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .avg_log2_i  (avg_log2_i),
        .adc_value_i (adc_value_i),
        .adc_valid_i (adc_valid_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .level_o     (level_o),
`ifdef ADC_AVG_WINDOW_EN
        .thr_lo_i    (thr_lo_i),
        .thr_hi_i    (thr_hi_i),
        .alarm_o     (alarm_o),
`endif
        .overflow_o  (overflow_o)
    );

    // All tasks start and end at posedge+1.
    task automatic send(input logic [NB-1:0] v);
        adc_value_i = v;
        adc_valid_i = 1'b1;
        @(posedge clk_i); #1;
        adc_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        idle(1);
        clear_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #2;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
        checks++; if (data_o !== 6'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", data_o); end
        checks++; if (level_o !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", overflow_o); end
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_avg_k2();
        avg_log2_i = 3'd2; ready_i = 1'b1;
        send(6'd10); send(6'd11); send(6'd12);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL k2_early: valid got %0b want 0", valid_o); end
        send(6'd13);
        checks++; if (valid_o !== 1'b1 || data_o !== 6'd11) begin errors++; $display("FAIL k2_avg: valid %0b data %0d want 1/11", valid_o, data_o); end
        checks++; if (level_o !== 4'd1) begin errors++; $display("FAIL k2_level1: got %0d want 1", level_o); end
        idle(1);
        checks++; if (level_o !== 4'd0 || valid_o !== 1'b0 || data_o !== 6'd0) begin errors++; $display("FAIL k2_drain: level %0d valid %0b data %0d want 0/0/0", level_o, valid_o, data_o); end
        ready_i = 1'b0;
    endtask

    task automatic test_overflow_k0();
        avg_log2_i = 3'd0; ready_i = 1'b0;
        for (int i = 1; i <= 8; i++) send(NB'(i));
        checks++; if (level_o !== 4'd8 || overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_full: level %0d ovf %0b want 8/0", level_o, overflow_o); end
        send(6'd9);
        checks++; if (level_o !== 4'd8 || overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_drop: level %0d ovf %0b want 8/1", level_o, overflow_o); end
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (valid_o !== 1'b1 || data_o !== NB'(i)) begin errors++; $display("FAIL ovf_pop%0d: valid %0b data %0d want 1/%0d", i, valid_o, data_o, i); end
            idle(1);
        end
        ready_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: valid %0b ovf %0b want 0/1", valid_o, overflow_o); end
        do_clear();
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b want 0", overflow_o); end
    endtask

    task automatic test_k4_max();
        avg_log2_i = 3'd4; ready_i = 1'b0;
        for (int i = 0; i < 15; i++) send(6'd63);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL k4_early: valid got %0b want 0", valid_o); end
        send(6'd63);
        checks++; if (valid_o !== 1'b1 || data_o !== 6'd63) begin errors++; $display("FAIL k4_avg: valid %0b data %0d want 1/63", valid_o, data_o); end
        // Exponent 7 clamps to 4: 0..15 sums to 120, 120>>4 = 7.
        ready_i = 1'b1;
        avg_log2_i = 3'd7;
        for (int i = 0; i < 15; i++) begin send(NB'(i)); ready_i = 1'b0; end
        checks++; if (valid_o !== 1'b0 || level_o !== 4'd0) begin errors++; $display("FAIL clamp_early: valid %0b level %0d want 0/0", valid_o, level_o); end
        send(6'd15);
        checks++; if (data_o !== 6'd7 || level_o !== 4'd1) begin errors++; $display("FAIL clamp_avg: data %0d level %0d want 7/1", data_o, level_o); end
        ready_i = 1'b1; idle(1); ready_i = 1'b0;
    endtask

    task automatic test_full_push_pop();
        avg_log2_i = 3'd0; ready_i = 1'b0;
        for (int i = 21; i <= 28; i++) send(NB'(i));
        checks++; if (level_o !== 4'd8) begin errors++; $display("FAIL pp_fill: level %0d want 8", level_o); end
        ready_i = 1'b1;
        send(6'd29);
        ready_i = 1'b0;
        checks++; if (level_o !== 4'd8 || overflow_o !== 1'b0 || data_o !== 6'd22) begin errors++; $display("FAIL pp_same: level %0d ovf %0b head %0d want 8/0/22", level_o, overflow_o, data_o); end
        ready_i = 1'b1;
        for (int i = 22; i <= 29; i++) begin
            checks++; if (data_o !== NB'(i)) begin errors++; $display("FAIL pp_order: data %0d want %0d", data_o, i); end
            idle(1);
        end
        ready_i = 1'b0;
        checks++; if (level_o !== 4'd0) begin errors++; $display("FAIL pp_empty: level %0d want 0", level_o); end
    endtask

    task automatic test_clear_mid();
        avg_log2_i = 3'd2; ready_i = 1'b0;
        send(6'd5); send(6'd7);
        do_clear();
        checks++; if (valid_o !== 1'b0 || level_o !== 4'd0) begin errors++; $display("FAIL clr_state: valid %0b level %0d want 0/0", valid_o, level_o); end
        send(6'd20); send(6'd20);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL clr_partial: valid %0b want 0", valid_o); end
        send(6'd20); send(6'd20);
        checks++; if (valid_o !== 1'b1 || data_o !== 6'd20 || level_o !== 4'd1) begin errors++; $display("FAIL clr_avg: valid %0b data %0d level %0d want 1/20/1", valid_o, data_o, level_o); end
        ready_i = 1'b1; idle(1); ready_i = 1'b0;
    endtask

    task automatic test_enable_hold();
        avg_log2_i = 3'd1; ready_i = 1'b0;
        send(6'd10);
        enable_i = 1'b0;
        send(6'd50);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL en_ignore: valid %0b want 0", valid_o); end
        enable_i = 1'b1;
        send(6'd12);
        checks++; if (valid_o !== 1'b1 || data_o !== 6'd11) begin errors++; $display("FAIL en_hold: valid %0b data %0d want 1/11", valid_o, data_o); end
        ready_i = 1'b1; idle(1); ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        avg_log2_i = 3'd0; ready_i = 1'b0;
        for (int i = 1; i <= 9; i++) send(NB'(i));
        avg_log2_i = 3'd2;
        send(6'd60); send(6'd60);
        #3 rst_ni = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || data_o !== 6'd0 || level_o !== 4'd0 || overflow_o !== 1'b0)
            begin errors++; $display("FAIL arst_now: valid %0b data %0d level %0d ovf %0b want all 0", valid_o, data_o, level_o, overflow_o); end
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        send(6'd8); send(6'd8);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL arst_nopartial: valid %0b want 0", valid_o); end
        send(6'd8); send(6'd8);
        checks++; if (valid_o !== 1'b1 || data_o !== 6'd8) begin errors++; $display("FAIL arst_block: valid %0b data %0d want 1/8", valid_o, data_o); end
        ready_i = 1'b1; idle(1); ready_i = 1'b0;
    endtask

`ifdef ADC_AVG_WINDOW_EN
    task automatic test_window();
        avg_log2_i = 3'd0; ready_i = 1'b1;
        thr_lo_i = 6'd16; thr_hi_i = 6'd40;
        send(6'd16);
        checks++; if (alarm_o !== 1'b0) begin errors++; $display("FAIL win_lo_edge: alarm %0b want 0", alarm_o); end
        send(6'd40);
        checks++; if (alarm_o !== 1'b0) begin errors++; $display("FAIL win_hi_edge: alarm %0b want 0", alarm_o); end
        send(6'd41);
        checks++; if (alarm_o !== 1'b1) begin errors++; $display("FAIL win_over: alarm %0b want 1", alarm_o); end
        idle(3);
        checks++; if (alarm_o !== 1'b1) begin errors++; $display("FAIL win_sticky: alarm %0b want 1", alarm_o); end
        do_clear();
        checks++; if (alarm_o !== 1'b0) begin errors++; $display("FAIL win_clear: alarm %0b want 0", alarm_o); end
        thr_lo_i = 6'd30; thr_hi_i = 6'd20;
        send(6'd25);
        checks++; if (alarm_o !== 1'b1) begin errors++; $display("FAIL win_inverted: alarm %0b want 1", alarm_o); end
        do_clear();
        thr_lo_i = 6'd0; thr_hi_i = 6'd63;
        ready_i = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        enable_i = 1'b1; clear_i = 1'b0; avg_log2_i = 3'd0;
        adc_value_i = '0; adc_valid_i = 1'b0; ready_i = 1'b0;
`ifdef ADC_AVG_WINDOW_EN
        thr_lo_i = 6'd0; thr_hi_i = 6'd63;
`endif
        test_reset();
        test_avg_k2();
        test_overflow_k0();
        test_k4_max();
        test_full_push_pop();
        test_clear_mid();
        test_enable_hold();
        test_async_reset();
`ifdef ADC_AVG_WINDOW_EN
        test_window();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
